// File: rtl/noc_local_injector.sv
// noc_local_injector
//   Tile-side injection stage feeding the local (P) input port of a lookahead
//   NoC router. Tile flits arrive on a ready/valid stream. A two-state FSM
//   checks head/tail framing on them. Well-formed flits go into a small FIFO,
//   and the FIFO head entry is offered to the router under the void/stop
//   protocol. Malformed flits are consumed and dropped, and they set a sticky
//   error flag.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : tile handshake (ready = FIFO not full)
//   in_data         : Width-2 bit payload
//   in_head/in_tail : framing bits (both set = single-flit packet)
//   data_p_out      : {head, tail, payload} of the FIFO head entry
//   data_void_out   : 1 when the FIFO is empty
//   stop_in         : router back-pressure; while 1 nothing pops
//   protocol_err    : sticky framing error
//   pkt_count       : tail flits delivered to the router, wrapping
module noc_local_injector #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-3:0] in_data,
  input  logic             in_head,
  input  logic             in_tail,
  output logic [Width-1:0] data_p_out,
  output logic             data_void_out,
  input  logic             stop_in,
  output logic             protocol_err,
  output logic [15:0]      pkt_count
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

  state_t                       state_q, state_d;
  logic [Depth-1:0][Width-1:0]  mem_q, mem_d;
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic                         err_q, err_d;
  logic [15:0]                  pkt_q, pkt_d;

  logic full, empty, accept, frame_ok, push, pop;

  assign full  = (count_q == CW'(Depth));
  assign empty = (count_q == '0);

  // Ready comes only from registered occupancy. Dropped flits are accepted
  // too, so a framing error never stalls the tile.
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;

  // A head is legal only between packets. A non-head is legal only inside one.
  assign frame_ok = (state_q == IDLE) ? in_head : !in_head;
  assign push     = accept && frame_ok;
  assign pop      = !empty && !stop_in;

  assign data_p_out    = mem_q[rd_ptr_q];
  assign data_void_out = empty;
  assign protocol_err  = err_q;
  assign pkt_count     = pkt_q;

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    pkt_d    = pkt_q;

    if (accept) begin
      if (frame_ok) begin
        // Tail closes the packet. A single-flit packet (head+tail) leaves
        // the FSM in IDLE.
        state_d = in_tail ? IDLE : BODY;
      end else begin
        err_d = 1'b1;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = {in_head, in_tail, in_data};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (mem_q[rd_ptr_q][Width-2]) pkt_d = pkt_q + 16'd1;
    end

    // Push while full cannot happen because ready is low, so count stays in range.
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      pkt_q    <= pkt_d;
    end
  end

endmodule

// File: tb/tb_noc_local_injector.sv
// Directed bench for noc_local_injector (Width=32, Depth=4).
// Inputs change 1 time unit after the rising edge, and outputs are checked there too.
module tb_noc_local_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] in_data;
  logic        in_head;
  logic        in_tail;
  logic [31:0] data_p_out;
  logic        data_void_out;
  logic        stop_in;
  logic        protocol_err;
  logic [15:0] pkt_count;

  int tests = 0;
  int fails = 0;

  noc_local_injector #(.Width(32), .Depth(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_head      (in_head),
    .in_tail      (in_tail),
    .data_p_out   (data_p_out),
    .data_void_out(data_void_out),
    .stop_in      (stop_in),
    .protocol_err (protocol_err),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic h, input logic t, input logic [29:0] d);
    in_valid = v; in_head = h; in_tail = t; in_data = d;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] prev_data;
  logic        prev_stop, prev_void;
  int          sent, recv, cyc;

  initial begin
    rst = 1'b1; stop_in = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_void", data_void_out, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", data_p_out, 32'h0);
    chk("rst_err", protocol_err, 0);
    chk("rst_pkt", pkt_count, 0);

    // Single-flit packet
    drive(1'b1, 1'b1, 1'b1, 30'h2A5A5A5);
    step();
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    chk("single_data", data_p_out, 32'hC2A5A5A5);
    chk("single_void", data_void_out, 0);
    chk("single_pkt_pre", pkt_count, 0);
    step();
    chk("single_void_after", data_void_out, 1);
    chk("single_pkt", pkt_count, 1);

    // 4-flit packet under stop, fill to full
    stop_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, i == 3, 30'h100 + 30'(i));
      chk("fill_ready", in_ready, 1);
      step();
    end
    chk("full_ready", in_ready, 0);
    drive(1'b1, 1'b1, 1'b0, 30'h1FF);
    step();
    chk("full_ready_hold", in_ready, 0);
    chk("full_hold_data", data_p_out, 32'h80000100);
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    stop_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_void", data_void_out, 0);
      chk("drain_data", data_p_out,
          {(i == 0) ? 1'b1 : 1'b0, (i == 3) ? 1'b1 : 1'b0, 30'h100 + 30'(i)});
      step();
      if (i == 0) chk("ready_after_pop", in_ready, 1);
    end
    chk("drain_empty", data_void_out, 1);
    chk("drain_pkt", pkt_count, 2);

    // 6-flit packet with stop toggling every cycle
    for (int i = 0; i < 6; i++)
      exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, (i == 5) ? 1'b1 : 1'b0, 30'h300 + 30'(i)});
    sent = 0; recv = 0; cyc = 0; prev_stop = 1'b0; prev_void = 1'b1; prev_data = '0;
    while (recv < 6 && cyc < 40) begin
      stop_in = (cyc % 2 == 0);
      if (sent < 6) drive(1'b1, sent == 0, sent == 5, 30'h300 + 30'(sent));
      else          drive(1'b0, 1'b0, 1'b0, 30'h0);
      if (prev_stop && !prev_void) begin
        chk("stop_hold_void", data_void_out, 0);
        chk("stop_hold_data", data_p_out, prev_data);
      end
      if (!data_void_out && !stop_in) begin
        chk("toggle_data", data_p_out, exp_q[recv]);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      prev_stop = stop_in; prev_void = data_void_out; prev_data = data_p_out;
      step();
      cyc++;
    end
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    stop_in = 1'b0;
    chk("toggle_recv", recv, 6);
    chk("toggle_empty", data_void_out, 1);
    chk("toggle_pkt", pkt_count, 3);

    // Framing: body flit in IDLE
    drive(1'b1, 1'b0, 1'b1, 30'h55);
    step();
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    chk("bad_body_void", data_void_out, 1);
    chk("bad_body_err", protocol_err, 1);
    chk("bad_body_pkt", pkt_count, 3);

    // Framing: head flit mid-packet is dropped, original packet completes
    drive(1'b1, 1'b1, 1'b0, 30'h400);
    step();
    chk("mid_head_data", data_p_out, 32'h80000400);
    drive(1'b1, 1'b1, 1'b1, 30'h4FF);
    step();
    chk("mid_drop_void", data_void_out, 1);
    drive(1'b1, 1'b0, 1'b1, 30'h401);
    step();
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    chk("mid_tail_data", data_p_out, 32'h40000401);
    step();
    chk("mid_done_void", data_void_out, 1);
    chk("mid_pkt", pkt_count, 4);
    chk("err_sticky", protocol_err, 1);

    // Wrap: stream single-flit packets until pkt_count reaches 0xFFFF
    drive(1'b1, 1'b1, 1'b1, 30'h7);
    repeat (65531) step();
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    step();
    chk("pre_wrap", pkt_count, 16'hFFFF);
    drive(1'b1, 1'b1, 1'b1, 30'h8);
    step();
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    step();
    chk("wrap", pkt_count, 16'h0000);
    chk("err_still", protocol_err, 1);

    // Reset mid-packet with 3 flits buffered
    stop_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 0, 1'b0, 30'h500 + 30'(i));
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    chk("pre_rst_void", data_void_out, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    stop_in = 1'b0;
    chk("mid_rst_void", data_void_out, 1);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_pkt", pkt_count, 0);
    chk("mid_rst_err", protocol_err, 0);
    chk("mid_rst_data", data_p_out, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 30'h501);
    step();
    drive(1'b0, 1'b0, 1'b0, 30'h0);
    chk("post_rst_body_void", data_void_out, 1);
    chk("post_rst_body_err", protocol_err, 1);
    step();
    chk("post_rst_pkt", pkt_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
